// File: rtl/cpu_run_ctrl_if.sv
// Board-side signal bundle for the run/step/halt controller: buttons, divider,
// breakpoint and PC in; pipeline enable, state and retired-pulse count out.
interface cpu_run_ctrl_if #(
    parameter int unsigned DIV_W = 24,
    parameter int unsigned CNT_W = 32
);
    logic             run_btn;
    logic             step_btn;
    logic             halt_btn;
    logic [DIV_W-1:0] div;
    logic             brk_en;
    logic [31:0]      brk_pc;
    logic [31:0]      pc;
    logic             cpu_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output run_btn, step_btn, halt_btn, div, brk_en, brk_pc, pc,
        input  cpu_en, state, cycle_cnt
    );

    modport slave (
        input  run_btn, step_btn, halt_btn, div, brk_en, brk_pc, pc,
        output cpu_en, state, cycle_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller: issues the single-cycle pipeline enable cpu_en for
// free-run at a divided rate, single-step, or halt, with an optional PC breakpoint.
module cpu_run_ctrl #(
    parameter int unsigned DIV_W = 24,
    parameter int unsigned CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    cpu_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2,
        StBrk  = 2'd3
    } state_e;

    state_e           state_q;
    logic             cpu_en_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic             skip_q;
    logic             run_q;
    logic             step_q;
    logic             halt_q;

    logic             run_edge;
    logic             step_edge;
    logic             halt_edge;
    logic             pc_match;
    logic             brk_hit;
    logic [DIV_W-1:0] div_m1;
    logic             tick;

    assign run_edge  = bus.run_btn & ~run_q;
    assign step_edge = bus.step_btn & ~step_q;
    assign halt_edge = bus.halt_btn & ~halt_q;
    assign pc_match  = (bus.pc == bus.brk_pc);
    assign brk_hit   = bus.brk_en & pc_match & ~skip_q;

    // div == 0 behaves as 1; >= lets a lowered div take effect immediately.
    assign div_m1 = (bus.div == '0) ? '0 : bus.div - DIV_W'(1);
    assign tick   = (div_cnt_q >= div_m1);

    always_ff @(posedge clk) begin
        // Button history tracks through reset so a held button gives no edge.
        run_q  <= bus.run_btn;
        step_q <= bus.step_btn;
        halt_q <= bus.halt_btn;

        if (rst) begin
            state_q     <= StHalt;
            cpu_en_q    <= 1'b0;
            cycle_cnt_q <= '0;
            div_cnt_q   <= '0;
            skip_q      <= 1'b0;
        end else begin
            if (cpu_en_q) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            skip_q <= skip_q & pc_match;

            unique case (state_q)
                StHalt, StBrk: begin
                    cpu_en_q <= 1'b0;
                    if (halt_edge) begin
                        state_q <= StHalt;
                    end else if (step_edge) begin
                        state_q <= StStep;
                    end else if (run_edge) begin
                        state_q   <= StRun;
                        div_cnt_q <= '0;
                        // Let the instruction at the breakpoint retire before re-arming.
                        if (pc_match) begin
                            skip_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (halt_edge) begin
                        state_q   <= StHalt;
                        cpu_en_q  <= 1'b0;
                        div_cnt_q <= '0;
                    end else if (brk_hit) begin
                        state_q   <= StBrk;
                        cpu_en_q  <= 1'b0;
                        div_cnt_q <= '0;
                    end else if (tick) begin
                        cpu_en_q  <= 1'b1;
                        div_cnt_q <= '0;
                    end else begin
                        cpu_en_q  <= 1'b0;
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                StStep: begin
                    state_q  <= StHalt;
                    cpu_en_q <= ~halt_edge;
                end
            endcase
        end
    end

    assign bus.cpu_en    = cpu_en_q;
    assign bus.state     = state_q;
    assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a per-cycle vector table followed by
// hand-written multi-cycle sequences for run, step, breakpoint and reset cases.
module tb_cpu_run_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cpu_run_ctrl_if #(.DIV_W(24), .CNT_W(32)) bus ();

    cpu_run_ctrl #(
        .DIV_W(24),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        run;
        logic        step;
        logic        halt;
        logic [23:0] div;
        logic        en;
        logic [1:0]  st;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic ru, input logic sp, input logic ha,
                           input logic [23:0] dv, input logic en, input logic [1:0] st,
                           input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.run = ru; v.step = sp; v.halt = ha; v.div = dv;
        v.en = en; v.st = st; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic en, input logic [1:0] st);
        check({name, ".cpu_en"}, 32'(bus.cpu_en), 32'(en));
        check({name, ".state"}, 32'(bus.state), 32'(st));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.run_btn  = 1'b0;
        bus.step_btn = 1'b0;
        bus.halt_btn = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.run_btn  = 1'b1;
        bus.step_btn = 1'b0;
        bus.halt_btn = 1'b0;
        bus.div      = 24'd1;
        bus.brk_en   = 1'b0;
        bus.brk_pc   = 32'h0;
        bus.pc       = 32'h0;

        //      rst   run   step  halt  div     en    st     cnt
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 24'd1, 1'b0, 2'd0, 32'd0);
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 24'd1, 1'b0, 2'd0, 32'd0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b0, 24'd1, 1'b0, 2'd0, 32'd0); // held through reset
        add_vec(1'b0, 1'b1, 1'b0, 1'b0, 24'd1, 1'b0, 2'd0, 32'd0);
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 24'd1, 1'b0, 2'd0, 32'd0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 24'd1, 1'b0, 2'd2, 32'd0); // step
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 24'd1, 1'b1, 2'd0, 32'd0);
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 24'd1, 1'b0, 2'd0, 32'd1);
        add_vec(1'b0, 1'b1, 1'b1, 1'b0, 24'd1, 1'b0, 2'd2, 32'd1); // step+run -> STEP
        add_vec(1'b0, 1'b0, 1'b0, 1'b1, 24'd1, 1'b0, 2'd0, 32'd1); // halt cancels step
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 24'd1, 1'b0, 2'd0, 32'd1);
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 24'd1, 1'b0, 2'd0, 32'd1); // halt+run -> HALT
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 24'd1, 1'b0, 2'd0, 32'd1);
        add_vec(1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0, 2'd1, 32'd1); // run, div=0 as 1
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 2'd1, 32'd1);
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 2'd1, 32'd2);
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 2'd1, 32'd3);
        add_vec(1'b0, 1'b0, 1'b0, 1'b1, 24'd0, 1'b0, 2'd0, 32'd4); // halt over tick
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 2'd0, 32'd4);

        foreach (vecs[i]) begin
            rst          = vecs[i].rst;
            bus.run_btn  = vecs[i].run;
            bus.step_btn = vecs[i].step;
            bus.halt_btn = vecs[i].halt;
            bus.div      = vecs[i].div;
            tick();
            chk($sformatf("vec%0d", i), vecs[i].en, vecs[i].st);
            check($sformatf("vec%0d.cnt", i), bus.cycle_cnt, vecs[i].cnt);
        end

        // div=4 free-run: 10 one-cycle pulses, 4 cycles apart, then halt.
        do_reset();
        bus.div = 24'd4;
        bus.run_btn = 1'b1;
        tick();
        chk("run4.entry", 1'b0, 2'd1);
        bus.run_btn = 1'b0;
        for (int p = 0; p < 10; p++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                chk($sformatf("run4.p%0d.c%0d", p, j), (j == 3), 2'd1);
            end
        end
        bus.halt_btn = 1'b1;
        tick();
        chk("run4.halt", 1'b0, 2'd0);
        check("run4.cnt", bus.cycle_cnt, 32'd10);
        bus.halt_btn = 1'b0;

        // Three spaced single steps.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.step_btn = 1'b1;
            tick();
            chk($sformatf("step%0d.enter", i), 1'b0, 2'd2);
            bus.step_btn = 1'b0;
            tick();
            chk($sformatf("step%0d.pulse", i), 1'b1, 2'd0);
            tick();
            chk($sformatf("step%0d.after", i), 1'b0, 2'd0);
            tick();
            tick();
        end
        check("step.cnt", bus.cycle_cnt, 32'd3);

        // Breakpoint at 0x10 with div=1; pc advances by 4 per pulse.
        do_reset();
        bus.brk_en = 1'b1;
        bus.brk_pc = 32'h10;
        bus.div    = 24'd1;
        bus.pc     = 32'h0;
        bus.run_btn = 1'b1;
        tick();
        chk("brk.entry", 1'b0, 2'd1);
        bus.run_btn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("brk.pulse%0d", i), 1'b1, 2'd1);
            bus.pc = bus.pc + 32'd4;
        end
        tick();
        chk("brk.hit", 1'b0, 2'd3);
        tick();
        chk("brk.hold", 1'b0, 2'd3);
        bus.run_btn = 1'b1;
        tick();
        chk("brk.resume", 1'b0, 2'd1);
        bus.run_btn = 1'b0;
        tick();
        chk("brk.skip", 1'b1, 2'd1);
        bus.pc = 32'h14;
        tick();
        chk("brk.past", 1'b1, 2'd1);
        bus.pc = 32'h10;
        tick();
        chk("brk.rearm", 1'b0, 2'd3);
        bus.brk_en = 1'b0;

        // Halt+run coinciding with a div=8 tick, then div lowered mid-count.
        do_reset();
        bus.div = 24'd8;
        bus.run_btn = 1'b1;
        tick();
        chk("d8.entry", 1'b0, 2'd1);
        bus.run_btn = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("d8.wait%0d", i), 1'b0, 2'd1);
        end
        bus.halt_btn = 1'b1;
        bus.run_btn  = 1'b1;
        tick();
        chk("d8.halt_on_tick", 1'b0, 2'd0);
        bus.halt_btn = 1'b0;
        bus.run_btn  = 1'b0;
        tick();
        chk("d8.idle", 1'b0, 2'd0);
        bus.run_btn = 1'b1;
        tick();
        chk("d8.rerun", 1'b0, 2'd1);
        bus.run_btn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("d8.cnt%0d", i), 1'b0, 2'd1);
        end
        bus.div = 24'd2;
        tick();
        chk("d8.lowered", 1'b1, 2'd1);

        // Reset on the edge where a pulse is due.
        do_reset();
        bus.div = 24'd4;
        bus.run_btn = 1'b1;
        tick();
        bus.run_btn = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst.first_pulse", 1'b1, 2'd1);
        tick();
        check("rst.cnt_before", bus.cycle_cnt, 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst.mid_run", 1'b0, 2'd0);
        check("rst.cnt", bus.cycle_cnt, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst.after", 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/halt controller for the pipelined RISC-V core on the FPGA board. It produces the single-cycle clock-enable pulse `cpu_en` that advances every pipeline register, and with it replaces the free-running divided clock with a clean single-clock enable. Debounced board buttons select free-run at a programmable divided rate, single-step, or halt. An optional PC breakpoint stops free-run.

## Interface
- `DIV_W`, 24: width of the divide-ratio input and divider counter.
- `CNT_W`, 32: width of the retired-enable counter.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `run_btn`  in  1  debounced level; a rising edge requests free-run.
- `step_btn`  in  1  debounced level; a rising edge requests one pipeline advance.
- `halt_btn`  in  1  debounced level; a rising edge requests halt.
- `div`  in  DIV_W  free-run period in `clk` cycles; 0 is treated as 1.
- `brk_en`  in  1  breakpoint enable.
- `brk_pc`  in  32  breakpoint address.
- `pc`  in  32  fetch-stage PC of the core.
- `cpu_en`  out  1  registered pipeline enable; high for exactly one cycle per advance.
- `state`  out  2  registered; 0=HALT, 1=RUN, 2=STEP, 3=BRK.
- `cycle_cnt`  out  CNT_W  number of `cpu_en` pulses issued; wraps.

## Operation
- **Edge detect**
  - Each button `b` is registered into `b_q`.
  - An edge is `b & ~b_q`, evaluated at the same clock edge.
  - During reset, `b_q <= b`, so a button held through reset produces no edge.
- **Priority** at a given edge: halt edge > breakpoint hit > step edge > run edge > divider tick.
- **HALT**
  - `cpu_en` = 0.
  - Run edge -> RUN with `div_cnt <= 0`. Also, if `pc == brk_pc`, `skip <= 1`.
  - Step edge -> STEP.
- **RUN**, evaluated at each edge, first match wins:
  - Halt edge -> HALT; `cpu_en <= 0`; `div_cnt <= 0`.
  - Breakpoint hit (`brk_en & pc == brk_pc & ~skip`) -> BRK; `cpu_en <= 0`; `div_cnt <= 0`.
  - Divider tick (`div_cnt >= eff_div-1`, where `eff_div = max(div,1)`) -> `div_cnt <= 0`, `cpu_en <= 1`.
  - Otherwise -> `div_cnt <= div_cnt+1`, `cpu_en <= 0`.
  - The `>=` comparison means lowering `div` mid-count takes effect at the next edge.
  - Run and step edges are ignored in RUN.
- **STEP**
  - At the next edge: `cpu_en <= 1`, state -> HALT.
  - The breakpoint is not checked; a step always executes.
  - A halt edge in this cycle wins: -> HALT with `cpu_en <= 0`.
- **BRK**
  - Behaves like HALT: a run edge resumes (setting `skip`), a step edge -> STEP.
  - A halt edge -> HALT.
- **skip**
  - Set on resume into RUN when `pc == brk_pc`.
  - Cleared at any edge where `pc != brk_pc`.
  - Guarantees the breakpointed instruction retires before the breakpoint re-arms.
- **cycle_cnt** increments at every edge where `cpu_en` is currently 1; it wraps at `2^CNT_W`.

## Timing
- **Reset values:** `cpu_en` = 0, `state` = HALT, `cycle_cnt` = 0, `div_cnt` = 0, `skip` = 0.
- **Reset mid-run:** a reset in any state forces the reset values at that edge. A pulse already registered is cancelled.
- **Run latency:** run edge sampled at edge k -> `state` = RUN after k. The first `cpu_en` pulse is high in the cycle after edge k+`eff_div`, then repeats every `eff_div` cycles.
- **Step latency:** step edge at edge k -> STEP after k. `cpu_en` is high for exactly the cycle after k+1, and `state` = HALT after k+1.
- **Halt latency:** halt edge at edge k -> `cpu_en` = 0 after k, even if a tick coincided at k.
- **Breakpoint latency:** a hit at edge k -> `cpu_en` = 0 after k, with no pulse at k.
- **Simultaneous edges:** halt + run on the same edge -> HALT. Step + run from HALT -> STEP.
- **div = 1:** `cpu_en` stays high every cycle from edge k+1 onward, and `cycle_cnt` increments every cycle.

## Test plan
- Reset with `run_btn` held high, then release reset -> `state` = 0, `cpu_en` = 0 and no RUN entry; a later fresh press enters RUN.
- `div` = 4, run press -> `cpu_en` pulses every 4 cycles, each exactly 1 cycle wide, first pulse 4 cycles after entry. After 10 pulses, halt -> `cycle_cnt` = 10, `state` = 0.
- Three step presses from HALT, spaced 5 cycles apart -> exactly 3 one-cycle `cpu_en` pulses; `state` sequence 0→2→0 each time; `cycle_cnt` = 3.
- `brk_en` = 1, `brk_pc` = 0x00000010, run with `div` = 1 and the bench incrementing `pc` by 4 per pulse from 0 -> BRK entered with `pc` = 0x10 and no pulse issued there.
  - Then run again -> pulses resume immediately (skip), `pc` advances to 0x14, and the breakpoint re-arms.
- In RUN with `div` = 8, drive halt and run edges on the same cycle as a divider tick -> no pulse on that cycle, `state` = HALT. Drive `div` from 8 to 2 when `div_cnt` = 5 -> tick on the next edge.
- Assert `rst` for 1 cycle mid-RUN, with a pulse due on that edge -> `cpu_en` = 0, `cycle_cnt` = 0, `state` = 0 the next cycle.
